sumador_cla_serie: RTL

- Parametrised sequential adder/subtractor that uses one 4-bit carry-lookahead group per clock.
- Computes a WIDTH-bit result in WIDTH/4 cycles.
- Carry between groups is held in a register, so wide operands do not need a full-width lookahead tree.
- Used wherever wide add/sub results can tolerate multi-cycle latency behind a start/done handshake.

---
 rtl/sumador_cla_serie.sv | 84 ++++++++
 1 files changed

// File: rtl/sumador_cla_serie.sv
// sumador_cla_serie: serial add/sub, one 4-bit lookahead group per clock; define SUMADOR_OVF_EN to add the ovf output.
module sumador_cla_serie #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co
`ifdef SUMADOR_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NG = WIDTH / 4;
  localparam int IW = NG > 1 ? $clog2(NG) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] op_a, op_b, res, res_nx;
  logic cr, last, accept;
  logic [3:0] ga, gb, p, g, sum;
  logic [4:0] c;
  always_comb begin
    ga = op_a[4*idx +: 4];
    gb = op_b[4*idx +: 4];
    p = ga ^ gb;
    g = ga & gb;
    c[0] = cr;
    c[1] = g[0] | (p[0] & cr);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cr);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cr);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cr);
    sum = p ^ c[3:0];
    res_nx = res;
    res_nx[4*idx +: 4] = sum;
    last = idx == IW'(NG - 1);
    accept = start && state != BUSY;
    state_nx = state == BUSY ? (last ? DONE : BUSY) : (start ? BUSY : IDLE);
  end
  assign busy = state == BUSY;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cr    <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      S     <= '0;
      Co    <= 1'b0;
`ifdef SUMADOR_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        op_a <= A;
        op_b <= B ^ {WIDTH{sub}};
        cr   <= Ci ^ sub;
        idx  <= '0;
      end else if (state == BUSY) begin
        res <= res_nx;
        cr  <= c[4];
        idx <= idx + IW'(1);
        if (last) begin
          S  <= res_nx;
          Co <= c[4];
`ifdef SUMADOR_OVF_EN
          ovf <= c[3] ^ c[4];
`endif
        end
      end
    end
  end
endmodule
